// File: rtl/mem_port_arbiter.sv
// Two-requester (imem/dmem) arbiter for one single-ported memory, one transaction in flight.
// Define MEM_PORT_ARB_RR_EN for round-robin priority instead of dmem-first with starvation limit.
package mem_bundle_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fcn;
        logic [2:0]  typ;
    } mem_req_t;

    typedef struct packed {
        mem_req_t req;
        logic     req_valid;
    } mem_in_t;

    typedef struct packed {
        logic [31:0] data;
    } mem_res_t;

    typedef struct packed {
        mem_res_t res;
        logic     req_ready;
        logic     res_valid;
    } mem_out_t;

    localparam logic [1:0] M_XRD = 2'd0;
    localparam logic [1:0] M_XWR = 2'd1;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;

endpackage

module mem_port_arbiter
    import mem_bundle_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  mem_in_t  imem_in,
    output mem_out_t imem_out,
    input  mem_in_t  dmem_in,
    output mem_out_t dmem_out,
    output mem_in_t  mem_in,
    input  mem_out_t mem_out,
    output logic     busy,
    output logic     err_spurious
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IMEM,
        OWN_DMEM
    } owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   lock_q, lock_d;
    logic   lock_dmem_q, lock_dmem_d;
    logic   err_q, err_d;
    logic   gnt_i, gnt_d;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_dmem_q, last_dmem_d;
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        lock_dmem_d = lock_dmem_q;
        err_d       = err_q;
`ifdef MEM_PORT_ARB_RR_EN
        last_dmem_d = last_dmem_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        mem_in   = '0;
        imem_out = '0;
        dmem_out = '0;

        unique case (state_q)
            S_IDLE: begin
                if (lock_q) begin
                    gnt_i = !lock_dmem_q && imem_in.req_valid;
                    gnt_d = lock_dmem_q && dmem_in.req_valid;
                end else if (imem_in.req_valid && dmem_in.req_valid) begin
`ifdef MEM_PORT_ARB_RR_EN
                    gnt_i = last_dmem_q;
`else
                    gnt_i = (starve_cnt_q == LIMIT);
`endif
                    gnt_d = !gnt_i;
                end else begin
                    gnt_i = imem_in.req_valid;
                    gnt_d = dmem_in.req_valid;
                end

                if (gnt_i) begin
                    mem_in              = imem_in;
                    imem_out.req_ready  = mem_out.req_ready;
                end
                if (gnt_d) begin
                    mem_in              = dmem_in;
                    dmem_out.req_ready  = mem_out.req_ready;
                end

                // An unaccepted grant is pinned; a dropped request frees it.
                lock_d      = (gnt_i || gnt_d) && !mem_out.req_ready;
                lock_dmem_d = gnt_d;

                if ((gnt_i || gnt_d) && mem_out.req_ready) begin
                    state_d = S_WAIT;
                    owner_d = gnt_d ? OWN_DMEM : OWN_IMEM;
`ifdef MEM_PORT_ARB_RR_EN
                    last_dmem_d = gnt_d;
`else
                    if (gnt_i) begin
                        starve_cnt_d = '0;
                    end else if (imem_in.req_valid && starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
`endif
                end

                if (mem_out.res_valid) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (owner_q == OWN_IMEM) begin
                    imem_out.res       = mem_out.res;
                    imem_out.res_valid = mem_out.res_valid;
                end
                if (owner_q == OWN_DMEM) begin
                    dmem_out.res       = mem_out.res;
                    dmem_out.res_valid = mem_out.res_valid;
                end
                if (mem_out.res_valid) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // Outputs must read zero for the whole time reset is held.
        if (!reset_n) begin
            mem_in   = '0;
            imem_out = '0;
            dmem_out = '0;
        end

        busy         = (state_q == S_WAIT) || mem_in.req_valid;
        err_spurious = err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            lock_q      <= 1'b0;
            lock_dmem_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_dmem_q <= 1'b0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            lock_dmem_q <= lock_dmem_d;
            err_q       <= err_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_dmem_q <= last_dmem_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_bundle_pkg::*;

    localparam int LIMIT = 4;

    logic     clk = 1'b0;
    logic     reset_n;
    mem_in_t  imem_in, dmem_in, mem_in;
    mem_out_t imem_out, dmem_out, mem_out;
    logic     busy, err_spurious;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: -1 none, 0 imem, 1 dmem.
    int m_own, m_held, m_run, m_prev;
    bit m_err;
    int lat, lat_mode, last_acc, obs_gnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_in     (imem_in),
        .imem_out    (imem_out),
        .dmem_in     (dmem_in),
        .dmem_out    (dmem_out),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .busy        (busy),
        .err_spurious(err_spurious)
    );

    task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic mem_in_t rnd_req();
        mem_in_t r;
        r.req.addr  = $urandom;
        r.req.data  = $urandom;
        r.req.fcn   = 2'($urandom_range(0, 1));
        r.req.typ   = 3'($urandom_range(1, 3));
        r.req_valid = 1'b1;
        return r;
    endfunction

    function automatic int pick();
        bit iv = imem_in.req_valid;
        bit dv = dmem_in.req_valid;
        if (m_own >= 0) return -1;
        if (m_held == 0) return iv ? 0 : -1;
        if (m_held == 1) return dv ? 1 : -1;
        if (iv && dv) begin
`ifdef MEM_PORT_ARB_RR_EN
            return (m_prev == 1) ? 0 : 1;
`else
            return (m_run >= LIMIT) ? 0 : 1;
`endif
        end
        if (iv) return 0;
        if (dv) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_held = -1;
        m_run  = 0;
        m_prev = 0;
        m_err  = 1'b0;
    endtask

    task automatic drive_mem(bit rdy);
        mem_out.req_ready = rdy;
        mem_out.res.data  = $urandom;
        mem_out.res_valid = 1'b0;
        if (m_own >= 0) begin
            if (lat == 0) mem_out.res_valid = 1'b1;
            else lat--;
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cyc();
        int w;
        mem_in_t  e_mi;
        mem_out_t e_i, e_d;
        #1;
        w    = pick();
        e_mi = '0;
        e_i  = '0;
        e_d  = '0;
        if (w == 0) begin
            e_mi          = imem_in;
            e_i.req_ready = mem_out.req_ready;
        end
        if (w == 1) begin
            e_mi          = dmem_in;
            e_d.req_ready = mem_out.req_ready;
        end
        if (m_own == 0) begin
            e_i.res       = mem_out.res;
            e_i.res_valid = mem_out.res_valid;
        end
        if (m_own == 1) begin
            e_d.res       = mem_out.res;
            e_d.res_valid = mem_out.res_valid;
        end
        chk("mem_in", mem_in, e_mi);
        chk("imem_out", 70'(imem_out), 70'(e_i));
        chk("dmem_out", 70'(dmem_out), 70'(e_d));
        chk("busy", busy, (m_own >= 0) || (w >= 0));
        chk("err_spurious", err_spurious, m_err);
        obs_gnt = imem_out.req_ready ? 0 : (dmem_out.req_ready ? 1 : -1);
        @(posedge clk);
        last_acc = -1;
        if (m_own >= 0) begin
            if (mem_out.res_valid) m_own = -1;
        end else begin
            if (mem_out.res_valid) m_err = 1'b1;
            if (w >= 0 && mem_out.req_ready) begin
                last_acc = w;
                m_own    = w;
                m_held   = -1;
                m_prev   = w;
                if (w == 0) m_run = 0;
                else if (imem_in.req_valid && m_run < LIMIT) m_run++;
                lat = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
            end else begin
                m_held = w;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        int exp_g;
        reset_n  = 1'b0;
        mem_out  = '0;
        lat      = 0;
        lat_mode = 0;
        last_acc = -1;
        obs_gnt  = -1;
        model_reset();

        // Reset: outputs stay zero even with live inputs.
        imem_in           = rnd_req();
        dmem_in           = rnd_req();
        mem_out.req_ready = 1'b1;
        mem_out.res_valid = 1'b1;
        mem_out.res.data  = $urandom;
        #12;
        chk("rst_mem_in", mem_in, '0);
        chk("rst_imem_out", 70'(imem_out), '0);
        chk("rst_dmem_out", 70'(dmem_out), '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_spurious, 1'b0);
        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;
        @(negedge clk);
        reset_n = 1'b1;

        // Single imem read with 1-cycle response.
        imem_in.req.addr  = 32'h100;
        imem_in.req.fcn   = M_XRD;
        imem_in.req.typ   = MT_W;
        imem_in.req_valid = 1'b1;
        drive_mem(1'b1);
        cyc();
        imem_in = '0;
        drive_mem(1'b1);
        mem_out.res.data = 32'hDEADBEEF;
        #1;
        chk("t2_res_valid", imem_out.res_valid, 1'b1);
        chk("t2_res_data", imem_out.res.data, 32'hDEADBEEF);
        chk("t2_dmem_rv", dmem_out.res_valid, 1'b0);
        cyc();

        // Both requesters always valid: grant order.
        k       = 0;
        imem_in = rnd_req();
        dmem_in = rnd_req();
        for (int c = 0; c < 20; c++) begin
            drive_mem(1'b1);
            cyc();
            if (last_acc >= 0) begin
`ifdef MEM_PORT_ARB_RR_EN
                exp_g = (k % 2 == 0) ? 1 : 0;
`else
                exp_g = (k % 5 == 4) ? 0 : 1;
`endif
                chk("t3_grant_order", 70'(obs_gnt), 70'(exp_g));
                k++;
                if (last_acc == 0) imem_in = rnd_req();
                else dmem_in = rnd_req();
            end
        end
        imem_in = '0;
        dmem_in = '0;
        drive_mem(1'b1);
        cyc();

        // Grant stays on imem while memory stalls, dmem waits.
        imem_in          = rnd_req();
        imem_in.req.addr = 32'h0000A000;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) dmem_in = rnd_req();
            drive_mem(1'b0);
            #1;
            chk("t4_lock_addr", mem_in.req.addr, 32'h0000A000);
            cyc();
        end
        drive_mem(1'b1);
        #1;
        chk("t4_imem_acc", imem_out.req_ready, 1'b1);
        chk("t4_dmem_held", dmem_out.req_ready, 1'b0);
        cyc();
        imem_in = '0;
        drive_mem(1'b1);
        cyc();
        drive_mem(1'b1);
        #1;
        chk("t4_dmem_next", dmem_out.req_ready, 1'b1);
        cyc();
        dmem_in = '0;
        drive_mem(1'b1);
        cyc();

        // Locked requester withdraws: one idle cycle, then re-arbitrate.
        imem_in = rnd_req();
        drive_mem(1'b0);
        cyc();
        imem_in = '0;
        dmem_in = rnd_req();
        drive_mem(1'b1);
        #1;
        chk("t4b_no_grant", mem_in.req_valid, 1'b0);
        cyc();
        drive_mem(1'b1);
        #1;
        chk("t4b_dmem_gnt", dmem_out.req_ready, 1'b1);
        cyc();
        dmem_in = '0;
        drive_mem(1'b1);
        cyc();

        // Spurious response in IDLE.
        drive_mem(1'b0);
        mem_out.res_valid = 1'b1;
        #1;
        chk("t5_err_before", err_spurious, 1'b0);
        cyc();
        drive_mem(1'b0);
        #1;
        chk("t5_err_set", err_spurious, 1'b1);
        cyc();
        for (int c = 0; c < 3; c++) begin
            drive_mem(1'b0);
            cyc();
        end

        // dmem store with 2-cycle response latency.
        lat_mode          = 1;
        dmem_in           = '0;
        dmem_in.req.addr  = 32'h2000;
        dmem_in.req.data  = 32'h12345678;
        dmem_in.req.fcn   = M_XWR;
        dmem_in.req.typ   = MT_W;
        dmem_in.req_valid = 1'b1;
        drive_mem(1'b1);
        #1;
        chk("t7_addr", mem_in.req.addr, 32'h2000);
        chk("t7_data", mem_in.req.data, 32'h12345678);
        chk("t7_fcn", mem_in.req.fcn, M_XWR);
        chk("t7_typ", mem_in.req.typ, MT_W);
        chk("t7_busy_present", busy, 1'b1);
        cyc();
        dmem_in = '0;
        drive_mem(1'b1);
        #1;
        chk("t7_busy_wait", busy, 1'b1);
        cyc();
        drive_mem(1'b1);
        #1;
        chk("t7_busy_resp", busy, 1'b1);
        chk("t7_res_valid", dmem_out.res_valid, 1'b1);
        cyc();
        drive_mem(1'b1);
        #1;
        chk("t7_busy_after", busy, 1'b0);
        cyc();

        // Random traffic.
        lat_mode = -1;
        for (int c = 0; c < 400; c++) begin
            if (!imem_in.req_valid && $urandom_range(0, 2) == 0) imem_in = rnd_req();
            if (!dmem_in.req_valid && $urandom_range(0, 2) == 0) dmem_in = rnd_req();
            drive_mem($urandom_range(0, 3) != 0);
            cyc();
            if (last_acc == 0) imem_in = '0;
            if (last_acc == 1) dmem_in = '0;
        end
        imem_in = '0;
        dmem_in = '0;
        for (int c = 0; c < 5; c++) begin
            drive_mem(1'b1);
            cyc();
        end

        // Reset while dmem owns the port.
        lat_mode = 2;
        dmem_in  = rnd_req();
        drive_mem(1'b1);
        cyc();
        dmem_in = rnd_req();
        drive_mem(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_mem_in", mem_in, '0);
        chk("t6_imem_out", 70'(imem_out), '0);
        chk("t6_dmem_out", 70'(dmem_out), '0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_err", err_spurious, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n  = 1'b1;
        dmem_in  = '0;
        imem_in  = rnd_req();
        lat_mode = 0;
        drive_mem(1'b1);
        #1;
        chk("t6_imem_gnt", imem_out.req_ready, 1'b1);
        cyc();
        imem_in = '0;
        drive_mem(1'b1);
        cyc();
        drive_mem(1'b0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
